booth_mult_share_arbiter: RTL
=============================

// Module: booth_mult_share_arbiter
// PURPOSE
//   Shares one pipelined radix-4 Booth 16x16 signed multiplier between NUM_REQ requesters.
//   Each requester has a valid/ready port. Round-robin arbitration issues at most one operand pair per cycle.
//   The requester ID is tracked alongside the multiplier pipeline. Results go into a response FIFO with valid/ready.
//   The multiplier cannot stall, so issue is credit-gated: no accepted result is ever dropped.
// PARAMETERS
//   NUM_REQ      4   number of requesters (2..8)
//   ID_W         2   requester ID width, >= clog2(NUM_REQ)
//   MUL_LATENCY  2   clock edges from operand capture to valid mul_product
//   RESP_DEPTH   4   response FIFO entries (power of 2, >= 2)
// PORTS
//   clk           in   1            clock, rising edge
//   rst           in   1            asynchronous reset, active-high
//   req_valid     in   NUM_REQ      per-requester operand valid
//   req_ready     out  NUM_REQ      per-requester accept (one-hot or zero)
//   req_a         in   NUM_REQ*16   packed signed multiplicands; requester i uses bits [16i+15:16i]
//   req_b         in   NUM_REQ*16   packed signed multipliers; same packing as req_a
//   resp_valid    out  1            response FIFO head valid
//   resp_ready    in   1            consumer accepts head
//   resp_product  out  32           signed product at FIFO head
//   resp_id       out  ID_W         requester index at FIFO head
//   mul_rst_n     out  1            drives multiplier rst_n (sync, active-low)
//   mul_a, mul_b  out  16 each      multiplier operands
//   mul_product   in   32           multiplier result
// BEHAVIOUR
//   Reset (rst=1, async):
//     - req_ready=0, resp_valid=0, resp_product=0, resp_id=0, mul_a=mul_b=0, mul_rst_n=0.
//     - RR pointer=0; tag pipe, FIFO and credits cleared.
//     - mul_rst_n is a flop: async-cleared by rst, loads 1 on the first clk edge after rst deasserts.
//     - No grants while mul_rst_n=0.
//   Reset mid-operation: all in-flight and buffered results are discarded, with no response emitted.
//   Credits: occupancy = FIFO count + in-flight tags. Issue is allowed only if occupancy < RESP_DEPTH.
//   Arbitration (combinational):
//     - If issue is allowed, grant the first requester with req_valid=1, searching from ptr upward, wrapping at NUM_REQ-1 -> 0.
//     - req_ready = one-hot grant, else 0.
//     - req_ready never depends on resp_ready in the same cycle; this avoids comb loops.
//     - On handshake (req_valid[i] & req_ready[i]), ptr <= (i+1) mod NUM_REQ. Without a handshake, ptr holds.
//   Operands:
//     - mul_a/mul_b = granted requester's req_a/req_b slice (combinational mux); they hold their last value when no grant.
//     - The multiplier samples them on the same edge as the handshake.
//   Tag pipe: MUL_LATENCY stages of {valid, id}.
//     - Stage 0 loads {handshake, granted id} at the handshake edge.
//     - When the last stage is valid, mul_product and the id are pushed into the FIFO at the next edge.
//   Latency: handshake in cycle t -> result visible as resp_valid in cycle t+MUL_LATENCY+1, if the FIFO was empty.
//   FIFO:
//     - First-word-fall-through. resp_* reflect the head; resp_* = 0 when empty.
//     - Pop on resp_valid & resp_ready.
//     - Simultaneous push and pop: count unchanged, ordering preserved. Pop when empty is ignored.
//     - Credit gating makes overflow impossible. The bench asserts: push while full never occurs.
//   Throughput: 1 result/cycle sustained when resp_ready=1. Results return in issue order.
//   Arithmetic:
//     - Operands are two's complement 16b; product is two's complement 32b.
//     - -32768*-32768 = 0x40000000, with no overflow.
// TESTING
//   1. Single request: req0 a=7 b=6, resp_ready=1 -> resp_valid 3 cycles after handshake; product=42, id=0.
//   2. Signed operands: req2 a=-3 b=5 -> 0xFFFFFFF1, id=2. Also a=b=0x8000 -> 0x40000000.
//   3. Round robin: all 4 requesters valid continuously -> grant order 0,1,2,3,0,1; one grant/cycle; ids return in the same order.
//   4. Backpressure: resp_ready=0 with continuous requests -> exactly 4 handshakes, then req_ready=0.
//      Raise resp_ready -> 4 ordered responses, then issue resumes.
//   5. Push/pop same cycle: FIFO holds 2 entries, resp_ready=1, new result arriving -> count stays 2, order intact.
//   6. Reset mid-flight: assert rst with 2 in flight and 1 buffered -> outputs 0 immediately, no stale response after release.
//      First grant comes only after mul_rst_n=1.

Source files
------------

// File: rtl/booth_mult_share_arbiter.sv
// Round-robin front end sharing one external pipelined 16x16 signed multiplier between
// NUM_REQ requesters, with a tag pipe that follows the multiplier and a credit-gated response FIFO.
module booth_mult_share_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ID_W        = 2,
    parameter int unsigned MUL_LATENCY = 2,
    parameter int unsigned RESP_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*16-1:0]   req_a,
    input  logic [NUM_REQ*16-1:0]   req_b,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [31:0]             resp_product,
    output logic [ID_W-1:0]         resp_id,
    output logic                    mul_rst_n,
    output logic [15:0]             mul_a,
    output logic [15:0]             mul_b,
    input  logic [31:0]             mul_product
);

    localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = $clog2(RESP_DEPTH + MUL_LATENCY + 1) + 1;

    logic [ID_W-1:0]        rr_ptr;
    logic                   gnt_found;
    logic [ID_W-1:0]        gnt_id;
    logic [ID_W-1:0]        cand;
    logic                   issue_ok;
    logic                   hs;

    logic [15:0]            a_arr [NUM_REQ];
    logic [15:0]            b_arr [NUM_REQ];
    logic [15:0]            op_a_q;
    logic [15:0]            op_b_q;

    logic [MUL_LATENCY-1:0] tag_v;
    logic [ID_W-1:0]        tag_id [MUL_LATENCY];
    logic [OCC_W-1:0]       inflight;
    logic [OCC_W-1:0]       occ;

    logic [31:0]            prod_mem [RESP_DEPTH];
    logic [ID_W-1:0]        id_mem   [RESP_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       fifo_cnt;
    logic                   push;
    logic                   pop;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[16*i +: 16];
        assign b_arr[i] = req_b[16*i +: 16];
    end

    // Credits: buffered plus in-flight results must stay below the FIFO depth.
    always_comb begin
        inflight = '0;
        for (int unsigned k = 0; k < MUL_LATENCY; k++) begin
            inflight = inflight + OCC_W'(tag_v[k]);
        end
        occ      = OCC_W'(fifo_cnt) + inflight;
        issue_ok = mul_rst_n && (occ < OCC_W'(RESP_DEPTH));
    end

    // Round-robin search starting at rr_ptr.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!gnt_found && issue_ok && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_id    = cand;
            end
        end
    end

    assign hs        = gnt_found;
    assign req_ready = gnt_found ? (NUM_REQ'(1) << gnt_id) : '0;
    assign mul_a     = gnt_found ? a_arr[gnt_id] : op_a_q;
    assign mul_b     = gnt_found ? b_arr[gnt_id] : op_b_q;

    assign push       = tag_v[MUL_LATENCY-1];
    assign resp_valid = (fifo_cnt != '0);
    assign pop        = resp_valid && resp_ready;
    assign resp_product = resp_valid ? prod_mem[rd_ptr] : '0;
    assign resp_id      = resp_valid ? id_mem[rd_ptr]   : '0;

    // Control state: pointer, operand hold, tag pipe, FIFO pointers, multiplier reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            mul_rst_n <= 1'b0;
            tag_v     <= '0;
            for (int unsigned k = 0; k < MUL_LATENCY; k++) begin
                tag_id[k] <= '0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
        end else begin
            mul_rst_n <= 1'b1;
            if (hs) begin
                rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
                op_a_q <= a_arr[gnt_id];
                op_b_q <= b_arr[gnt_id];
            end
            tag_v[0]  <= hs;
            tag_id[0] <= gnt_id;
            for (int unsigned k = 1; k < MUL_LATENCY; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Payload storage needs no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            prod_mem[wr_ptr] <= mul_product;
            id_mem[wr_ptr]   <= tag_id[MUL_LATENCY-1];
        end
    end

endmodule
